// File: rtl/seg_scan_mux_if.sv
// +---------------------------------------------------------------------------+
// | seg_scan_mux_if: per-digit segment inputs and scanned display outputs.     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

interface seg_scan_mux_if;
  logic       enable;
  logic [6:0] Display0;
  logic [6:0] Display1;
  logic [6:0] Display2;
  logic [6:0] Display3;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output enable, Display0, Display1, Display2, Display3, digit_en,
    input  seg, an, frame_tick
  );

  modport slave (
    input  enable, Display0, Display1, Display2, Display3, digit_en,
    output seg, an, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// +---------------------------------------------------------------------------+
// | seg_scan_mux: time-multiplexed four-digit seven-segment scanner with      |
// | per-frame snapshot, anti-ghosting blank gap and leading-digit masking.    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module seg_scan_mux #(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  wire             Clock,
  input  wire             reset,
  seg_scan_mux_if.slave   bus
);

  localparam int c_MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int c_CW   = $clog2(c_MAXC + 1);
  localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL - 1);
  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK - 1);
  localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);
  localparam logic [6:0]      c_SEG_DARK   = 7'h7F;
  localparam logic [3:0]      c_AN_DARK    = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_GAP   = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_digit;
  logic [c_CW-1:0]  r_cnt;
  logic [3:0][6:0]  r_shadow;
  logic [3:0]       r_en;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_frame_tick;

  logic [1:0]       w_sel;
  logic [6:0]       w_lit_seg;
  logic [3:0]       w_lit_an;
  logic             w_dwell_done;
  logic             w_capture;

  // Digit about to be lit on the next SHOW entry; outputs are computed for
  // the state being entered so that an and seg switch on the same edge.
  always_comb begin
    w_sel = r_digit;
    if (r_state == S_SHOW) begin
      w_sel = r_digit + 2'd1;
    end else if (r_state == S_LATCH) begin
      w_sel = 2'd0;
    end
    w_lit_seg = r_en[w_sel] ? r_shadow[w_sel] : c_SEG_DARK;
    w_lit_an  = r_en[w_sel] ? ~(4'b0001 << w_sel) : c_AN_DARK;
  end

  assign w_dwell_done = (r_state == S_SHOW) && (r_cnt == c_DWELL_LAST);
  assign w_capture    = bus.enable &&
                        ((r_state == S_IDLE) || (w_dwell_done && (r_digit == 2'd3)));

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_shadow <= {4{c_SEG_DARK}};
      r_en     <= 4'b0000;
    end else if (w_capture) begin
      r_shadow <= {bus.Display3, bus.Display2, bus.Display1, bus.Display0};
      r_en     <= bus.digit_en;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_digit      <= 2'd0;
      r_cnt        <= '0;
      r_seg        <= c_SEG_DARK;
      r_an         <= c_AN_DARK;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (!bus.enable) begin
        r_state <= S_IDLE;
        r_digit <= 2'd0;
        r_cnt   <= '0;
        r_seg   <= c_SEG_DARK;
        r_an    <= c_AN_DARK;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state      <= S_LATCH;
            r_digit      <= 2'd0;
            r_cnt        <= '0;
            r_frame_tick <= 1'b1;
          end
          S_LATCH: begin
            r_cnt <= '0;
            if (BLANK > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_SHOW;
              r_seg   <= w_lit_seg;
              r_an    <= w_lit_an;
            end
          end
          S_GAP: begin
            if (r_cnt == c_BLANK_LAST) begin
              r_state <= S_SHOW;
              r_cnt   <= '0;
              r_seg   <= w_lit_seg;
              r_an    <= w_lit_an;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          S_SHOW: begin
            if (w_dwell_done) begin
              r_cnt <= '0;
              if (r_digit == 2'd3) begin
                r_state      <= S_LATCH;
                r_digit      <= 2'd0;
                r_frame_tick <= 1'b1;
                r_seg        <= c_SEG_DARK;
                r_an         <= c_AN_DARK;
              end else if (BLANK > 0) begin
                r_state <= S_GAP;
                r_digit <= r_digit + 2'd1;
                r_seg   <= c_SEG_DARK;
                r_an    <= c_AN_DARK;
              end else begin
                r_digit <= r_digit + 2'd1;
                r_seg   <= w_lit_seg;
                r_an    <= w_lit_an;
              end
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire
